// File: rtl/fifo_arbiter.sv
// Two-producer write arbiter and 3-state read sequencer wrapped around an external FIFO.
// Define FIFO_ARB_FIXED_PRIO_EN to give producer 0 fixed priority on contention (default: round-robin).
module fifo_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p0_valid,
    input  logic [WIDTH-1:0] p0_data,
    output logic             p0_ready,
    input  logic             p1_valid,
    input  logic [WIDTH-1:0] p1_data,
    output logic             p1_ready,
    output logic             fifo_wr_en,
    output logic [WIDTH-1:0] fifo_din,
    input  logic             fifo_full,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             last_grant
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } rd_state_t;

    rd_state_t        state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_s;
    logic             grant_idx_s;

    // Write arbitration: pick a producer from the valids, full flag and previous winner.
    always_comb begin
        grant_s     = 1'b0;
        grant_idx_s = 1'b0;
        if (rst || fifo_full) begin
            grant_s = 1'b0;
        end else if (p0_valid && p1_valid) begin
            grant_s = 1'b1;
`ifdef FIFO_ARB_FIXED_PRIO_EN
            grant_idx_s = 1'b0;
`else
            grant_idx_s = ~last_grant_q;
`endif
        end else if (p0_valid) begin
            grant_s     = 1'b1;
            grant_idx_s = 1'b0;
        end else if (p1_valid) begin
            grant_s     = 1'b1;
            grant_idx_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Drive producer handshakes and FIFO write port from the grant decision.
    always_comb begin
        p0_ready     = 1'b0;
        p1_ready     = 1'b0;
        fifo_wr_en   = 1'b0;
        fifo_din     = {WIDTH{1'b0}};
        last_grant_d = last_grant_q;
        if (grant_s) begin
            p0_ready     = ~grant_idx_s;
            p1_ready     = grant_idx_s;
            fifo_wr_en   = 1'b1;
            fifo_din     = grant_idx_s ? p1_data : p0_data;
            last_grant_d = grant_idx_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Read sequencer next state; the read strobe is issued in the same cycle as the decision.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        fifo_rd_en  = 1'b0;
        if (rst) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    out_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_rd_en = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    out_data_d  = fifo_dout;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
                ST_HOLD: begin
                    if (!out_ready) begin
                        state_d = ST_HOLD;
                    end else if (!fifo_empty) begin
                        fifo_rd_en  = 1'b1;
                        out_valid_d = 1'b0;
                        state_d     = ST_FETCH;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            endcase
        end
    end

    // State registers; reset leaves last_grant at 1 so producer 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_data_q   <= {WIDTH{1'b0}};
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Randomized bench for fifo_arbiter: behavioural FIFO environment plus a transaction-level reference model.
module tb_fifo_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
`ifdef FIFO_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             p0_valid, p1_valid;
    logic [WIDTH-1:0] p0_data, p1_data;
    logic             p0_ready, p1_ready;
    logic             fifo_wr_en, fifo_rd_en;
    logic [WIDTH-1:0] fifo_din, fifo_dout;
    logic             fifo_full, fifo_empty;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_data;
    logic             last_grant;

    // External FIFO environment
    logic [WIDTH-1:0] env_q[$];
    int               env_cnt;
    logic             force_full;

    // Reference model state
    logic [WIDTH-1:0] m_stream[$];
    int               m_last;
    bit               m_busy, m_held, m_known;
    logic [WIDTH-1:0] m_infl, m_out_data;

    int n_checks, n_errors;

    assign fifo_full  = (env_cnt >= DEPTH) || force_full;
    assign fifo_empty = (env_cnt == 0);

    fifo_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .p0_valid   (p0_valid),
        .p0_data    (p0_data),
        .p0_ready   (p0_ready),
        .p1_valid   (p1_valid),
        .p1_data    (p1_data),
        .p1_ready   (p1_ready),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .fifo_full  (fifo_full),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .last_grant (last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic preload(input logic [WIDTH-1:0] w);
        env_q.push_back(w);
        env_cnt = env_q.size();
        m_stream.push_back(w);
    endtask

    // One clock: drive inputs, check against the model before the edge, then advance FIFO and model.
    task automatic run_cycle(input bit r, input bit v0, input bit v1, input logic [WIDTH-1:0] d0,
                             input logic [WIDTH-1:0] d1, input bit ff, input bit ordy);
        int  grant;
        bit  exp_rd, cap_wr, cap_rd;
        logic [WIDTH-1:0] cap_din;
        @(negedge clk);
        rst = r; p0_valid = v0; p1_valid = v1; p0_data = d0; p1_data = d1;
        force_full = ff; out_ready = ordy;
        #1;
        grant = -1;
        if (!r && !((env_cnt >= DEPTH) || ff)) begin
            if (v0 && v1) grant = FIXED ? 0 : (1 - m_last);
            else if (v0)  grant = 0;
            else if (v1)  grant = 1;
        end
        exp_rd = !r && (env_cnt != 0) && !m_busy && (!m_held || ordy);
        check_eq("p0_ready", {31'd0, p0_ready}, {31'd0, grant == 0});
        check_eq("p1_ready", {31'd0, p1_ready}, {31'd0, grant == 1});
        check_eq("fifo_wr_en", {31'd0, fifo_wr_en}, {31'd0, grant >= 0});
        if (grant >= 0) check_eq("fifo_din", {24'd0, fifo_din}, {24'd0, (grant == 1) ? d1 : d0});
        if (m_known || r) check_eq("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
        if (m_known) begin
            check_eq("last_grant", {31'd0, last_grant}, m_last);
            check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_held});
            check_eq("out_data", {24'd0, out_data}, {24'd0, m_out_data});
        end
        cap_wr = fifo_wr_en; cap_rd = fifo_rd_en; cap_din = fifo_din;
        @(posedge clk);
        #1;
        if (cap_rd && env_q.size() > 0) fifo_dout = env_q.pop_front();
        if (cap_wr && env_q.size() < DEPTH) env_q.push_back(cap_din);
        env_cnt = env_q.size();
        if (r) begin
            m_last = 1; m_busy = 1'b0; m_held = 1'b0; m_out_data = '0; m_known = 1'b1;
        end else begin
            if (m_busy) begin
                m_held = 1'b1; m_out_data = m_infl;
            end else if (m_held && ordy) begin
                m_held = 1'b0;
            end
            if (exp_rd && m_stream.size() > 0) m_infl = m_stream.pop_front();
            if (grant >= 0) begin
                m_last = grant;
                m_stream.push_back((grant == 1) ? d1 : d0);
            end
            m_busy = exp_rd;
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        env_cnt = 0; force_full = 1'b0; fifo_dout = '0;
        rst = 1'b1; p0_valid = 1'b0; p1_valid = 1'b0; p0_data = '0; p1_data = '0; out_ready = 1'b0;
        m_last = 1; m_busy = 1'b0; m_held = 1'b0; m_known = 1'b0; m_infl = '0; m_out_data = '0;

        repeat (2) run_cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Continuous contention: alternating grants starting with p0
        for (int i = 0; i < 6; i++)
            run_cycle(1'b0, 1'b1, 1'b1, 8'h10 + 8'(i), 8'h80 + 8'(i), 1'b0, 1'b1);
        // Full for three cycles, then release with both still valid
        for (int i = 0; i < 3; i++)
            run_cycle(1'b0, 1'b1, 1'b1, 8'h20, 8'h90, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++)
            run_cycle(1'b0, 1'b1, 1'b1, 8'h21 + 8'(i), 8'h91 + 8'(i), 1'b0, 1'b1);
        repeat (30) run_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Preloaded pair drained by an always-ready consumer
        run_cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        preload(8'hA5); preload(8'h3C);
        repeat (8) run_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Consumer stalls in HOLD, then accepts
        preload(8'h7E);
        repeat (8) run_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) run_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Reset while holding a word
        preload(8'h11);
        repeat (4) run_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) run_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        if (FIXED) begin
            for (int i = 0; i < 4; i++)
                run_cycle(1'b0, 1'b1, 1'b1, 8'h40 + 8'(i), 8'hC0 + 8'(i), 1'b0, 1'b1);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            run_cycle(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
                      8'($urandom), 8'($urandom), ($urandom_range(0, 9) == 0), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
